// File: rtl/riscv_instr_arb_pkg.sv
// Shared types and width helpers for the instruction-port arbiter.
// Index fields are sized for the largest supported requester count (8).
package riscv_instr_arb_pkg;

  localparam int ARB_IDX_W  = 3;
  localparam int PERF_CNT_W = 32;

  // Requester ID width, never below one bit.
  function automatic int arb_id_w(input int nb_req);
    return (nb_req <= 2) ? 1 : $clog2(nb_req);
  endfunction

  // Width able to hold 0..max_out outstanding transactions.
  function automatic int arb_cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  typedef struct packed {
    logic [ARB_IDX_W-1:0] rr_ptr;
    logic                 lock;
    logic [ARB_IDX_W-1:0] lock_id;
  } arb_state_t;

endpackage

// File: rtl/riscv_instr_arb_id_fifo.sv
// Owner-ID FIFO for outstanding fetches. The head is readable in the same
// cycle it is popped, and push+pop together keeps the count unchanged.
module riscv_instr_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [ID_W-1:0]  push_id_i,
  input  logic             pop_i,
  output logic [ID_W-1:0]  head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ID storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_id_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Shares one instruction-memory request port between NB_REQ fetch units.
// Requests pass combinationally, responses return in order via an ID FIFO.
// Optional build macro RISCV_INSTR_ARB_PERF_EN adds per-requester grant and
// stall counters with a synchronous clear.
//
// lock | meaning
// 0    | round-robin from rr_ptr
// 1    | lock_id keeps the port while it still requests (stalled or blocked)
module riscv_instr_port_arbiter
  import riscv_instr_arb_pkg::*;
#(
  parameter int NB_REQ          = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NB_REQ-1:0]        req_i,
  input  logic [NB_REQ*ADDR_W-1:0] addr_i,
  output logic [NB_REQ-1:0]        gnt_o,
  output logic [NB_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [NB_REQ-1:0]        err_pmp_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_err_pmp_i,
  output logic                     busy_o,
  output logic                     proto_err_o
`ifdef RISCV_INSTR_ARB_PERF_EN
  ,
  input  logic                         perf_clr_i,
  output logic [NB_REQ*PERF_CNT_W-1:0] grant_cnt_o,
  output logic [NB_REQ*PERF_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int ID_W  = arb_id_w(NB_REQ);
  localparam int CNT_W = arb_cnt_w(MAX_OUTSTANDING);

  arb_state_t           st_q, st_d;
  logic [ARB_IDX_W-1:0] winner;
  logic                 lock_hit, any_req, can_issue, hshk, push, pop;
  logic [ID_W-1:0]      head_id;
  logic [CNT_W-1:0]     count;
  logic                 empty, proto_err_q;

  assign any_req   = |req_i;
  assign can_issue = (count < CNT_W'(MAX_OUTSTANDING)) | mem_rvalid_i;
  assign mem_req_o = any_req & can_issue;
  assign hshk      = mem_req_o & mem_gnt_i;
  assign push      = hshk & ~mem_err_pmp_i;
  assign pop       = mem_rvalid_i & ~empty;

  // Winner: held lock first, otherwise first requester at or after rr_ptr.
  // Descending scan so the smallest rotation distance is assigned last.
  always_comb begin
    lock_hit = 1'b0;
    for (int i = 0; i < NB_REQ; i++)
      if (st_q.lock && st_q.lock_id == ARB_IDX_W'(i) && req_i[i]) lock_hit = 1'b1;
    winner = '0;
    if (lock_hit) begin
      winner = st_q.lock_id;
    end else begin
      for (int k = NB_REQ - 1; k >= 0; k--)
        for (int i = 0; i < NB_REQ; i++)
          if (req_i[i] && ARB_IDX_W'(i) == ARB_IDX_W'((int'(st_q.rr_ptr) + k) % NB_REQ))
            winner = ARB_IDX_W'(i);
    end
  end

  // Per-requester grant, fault, response routing and address mux.
  always_comb begin
    gnt_o      = '0;
    err_pmp_o  = '0;
    rvalid_o   = '0;
    mem_addr_o = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (winner == ARB_IDX_W'(i)) begin
        gnt_o[i]     = hshk;
        err_pmp_o[i] = hshk & mem_err_pmp_i;
        if (any_req) mem_addr_o = addr_i[i*ADDR_W +: ADDR_W];
      end
      rvalid_o[i] = pop & (head_id == ID_W'(i));
    end
  end

  assign rdata_o = mem_rvalid_i ? mem_rdata_i : '0;
  assign busy_o  = (count != '0) | mem_req_o;

  // Next arbiter state: advance on handshake, lock onto a waiting winner.
  always_comb begin
    st_d = st_q;
    if (hshk) begin
      st_d.rr_ptr = ARB_IDX_W'((int'(winner) + 1) % NB_REQ);
      st_d.lock   = 1'b0;
    end else if (any_req) begin
      st_d.lock    = 1'b1;
      st_d.lock_id = winner;
    end else begin
      st_d.lock = 1'b0;
    end
  end

  // Arbiter state and sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (mem_rvalid_i && empty) proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;

  riscv_instr_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_id_i (winner[ID_W-1:0]),
    .pop_i     (pop),
    .head_o    (head_id),
    .count_o   (count),
    .empty_o   (empty)
  );

`ifdef RISCV_INSTR_ARB_PERF_EN
  for (genvar g = 0; g < NB_REQ; g++) begin : g_perf
    logic [PERF_CNT_W-1:0] gcnt_q, scnt_q;

    // Saturating grant and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gcnt_q <= '0;
        scnt_q <= '0;
      end else if (perf_clr_i) begin
        gcnt_q <= '0;
        scnt_q <= '0;
      end else begin
        if (gnt_o[g] && gcnt_q != '1) gcnt_q <= gcnt_q + 1'b1;
        if (req_i[g] && !gnt_o[g] && scnt_q != '1) scnt_q <= scnt_q + 1'b1;
      end
    end

    assign grant_cnt_o[g*PERF_CNT_W +: PERF_CNT_W] = gcnt_q;
    assign stall_cnt_o[g*PERF_CNT_W +: PERF_CNT_W] = scnt_q;
  end
`endif

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Randomised and directed bench for riscv_instr_port_arbiter with a
// queue-based reference model of the arbitration and response routing.
module tb_riscv_instr_port_arbiter;

  localparam int NB   = 2;
  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NB-1:0]     req;
  logic [NB*AW-1:0]  addr;
  logic [NB-1:0]     gnt_o, rvalid_o, err_pmp_o;
  logic [DW-1:0]     rdata_o;
  logic              mem_req_o, mem_gnt, mem_rvalid, mem_pmp;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_rdata;
  logic              busy_o, proto_err_o;
`ifdef RISCV_INSTR_ARB_PERF_EN
  logic              perf_clr = 1'b0;
  logic [NB*32-1:0]  grant_cnt, stall_cnt;
`endif

  riscv_instr_port_arbiter #(.NB_REQ(NB), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .addr_i        (addr),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_pmp_o     (err_pmp_o),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt),
    .mem_addr_o    (mem_addr_o),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .mem_err_pmp_i (mem_pmp),
    .busy_o        (busy_o),
    .proto_err_o   (proto_err_o)
`ifdef RISCV_INSTR_ARB_PERF_EN
    ,
    .perf_clr_i    (perf_clr),
    .grant_cnt_o   (grant_cnt),
    .stall_cnt_o   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: owner queue, rotating pointer, optional held requester.
  int m_q[$];
  int m_rr;
  bit m_lk;
  int m_lk_id;
  bit m_perr;
  int m_w;
  logic          e_mreq, e_busy;
  logic [AW-1:0] e_addr;
  logic [NB-1:0] e_gnt, e_err, e_rv;

  function automatic logic [AW-1:0] addr_of(input int i);
    logic [NB*AW-1:0] a;
    a = addr;
    return a[i*AW +: AW];
  endfunction

  task automatic model_eval();
    bit any;
    any = (req != '0);
    m_w = 0;
    if (m_lk && req[m_lk_id]) m_w = m_lk_id;
    else
      for (int k = 0; k < NB; k++)
        if (req[(m_rr + k) % NB]) begin
          m_w = (m_rr + k) % NB;
          break;
        end
    e_mreq = any && (m_q.size() < MAXO || mem_rvalid);
    e_addr = any ? addr_of(m_w) : '0;
    e_gnt  = (e_mreq && mem_gnt) ? NB'(1 << m_w) : '0;
    e_err  = mem_pmp ? e_gnt : '0;
    e_rv   = (mem_rvalid && m_q.size() > 0) ? NB'(1 << m_q[0]) : '0;
    e_busy = (m_q.size() != 0) || e_mreq;
  endtask

  task automatic model_update();
    if (mem_rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_perr = 1'b1;
    end
    if (e_gnt != '0) begin
      m_rr = (m_w + 1) % NB;
      m_lk = 1'b0;
      if (!mem_pmp) m_q.push_back(m_w);
    end else if (req != '0) begin
      m_lk = 1'b1;
      m_lk_id = m_w;
    end else begin
      m_lk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr = 0;
    m_lk = 1'b0;
    m_lk_id = 0;
    m_perr = 1'b0;
  endtask

  task automatic sample();
    #1;
    model_eval();
    chk("mem_req", mem_req_o, e_mreq);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("gnt", gnt_o, e_gnt);
    chk("err_pmp", err_pmp_o, e_err);
    chk("rvalid", rvalid_o, e_rv);
    chk("busy", busy_o, e_busy);
    chk("proto_err", proto_err_o, m_perr);
    if (mem_rvalid) chk("rdata", rdata_o, mem_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NB-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic g, input logic rv, input logic [DW-1:0] d, input logic pmp);
    req = r;
    addr = {a1, a0};
    mem_gnt = g;
    mem_rvalid = rv;
    mem_rdata = d;
    mem_pmp = pmp;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      drive('0, '0, '0, 1'b0, m_q.size() > 0, DW'(32'hD000 + i), 1'b0);
      cyc();
    end
  endtask

  task automatic do_reset(input logic rv_during);
    drive('0, '0, '0, 1'b0, rv_during, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_proto", proto_err_o, 1'b0);
    chk("rst_rvalid", rvalid_o, '0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_gnt", gnt_o, '0);
    chk("reset_addr", mem_addr_o, '0);
    chk("reset_proto", proto_err_o, 1'b0);
    rst_n = 1'b1;

    // Simultaneous requests alternate; a response each cycle keeps room.
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 32'h10, 32'h20, 1'b1, m_q.size() > 0, DW'(32'hA0 + i), 1'b0);
      sample();
      chk("alt_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      advance();
    end
    drain();

    // Requester 0 stalls three cycles and retargets; it keeps the port.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, (i >= 2) ? 32'h200 : 32'h100, 32'h400, i >= 3, 1'b0, '0, 1'b0);
      sample();
      if (i == 2) chk("lock_addr", mem_addr_o, 32'h200);
      if (i == 3) chk("lock_gnt0", gnt_o, 2'b01);
      if (i == 4) chk("lock_gnt1", gnt_o, 2'b10);
      advance();
    end
    drain();

    // Full FIFO blocks; a response frees the slot in the same cycle.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 32'h30 + i, '0, 1'b1, i == 3, 32'hCAFE, 1'b0);
      sample();
      if (i == 2) chk("full_block", mem_req_o, 1'b0);
      if (i == 3) begin
        chk("full_rvalid", rvalid_o, 2'b01);
        chk("full_req", mem_req_o, 1'b1);
      end
      advance();
    end
    drain();

    // Interleaved owners receive their own responses in order.
    do_reset(1'b0);
    drive(2'b01, 32'h10, '0, 1'b1, 1'b0, '0, 1'b0); cyc();
    drive(2'b10, '0, 32'h20, 1'b1, 1'b0, '0, 1'b0); cyc();
    drive('0, '0, '0, 1'b0, 1'b1, 32'hAAAA, 1'b0);
    sample();
    chk("il_rv_a", rvalid_o, 2'b01);
    chk("il_data_a", rdata_o, 32'hAAAA);
    advance();
    drive('0, '0, '0, 1'b0, 1'b1, 32'hBBBB, 1'b0);
    sample();
    chk("il_rv_b", rvalid_o, 2'b10);
    chk("il_data_b", rdata_o, 32'hBBBB);
    advance();

    // PMP fault on requester 1: flagged, nothing outstanding afterwards.
    drive(2'b10, '0, 32'h80, 1'b1, 1'b0, '0, 1'b1);
    sample();
    chk("pmp_err", err_pmp_o, 2'b10);
    advance();
    drive('0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    sample();
    chk("pmp_busy", busy_o, 1'b0);
    advance();

    // Response with nothing outstanding raises a sticky error.
    drive('0, '0, '0, 1'b0, 1'b1, 32'h5, 1'b0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 32'h44, '0, 1'b0, 1'b0, '0, 1'b0);
      sample();
      chk("proto_sticky", proto_err_o, 1'b1);
      advance();
    end

    // Randomised traffic.
    do_reset(1'b0);
    for (int i = 0; i < 2000; i++) begin
      drive(NB'($urandom_range(0, 3)), $urandom, $urandom, ($urandom % 4) != 0,
            (m_q.size() > 0) && ($urandom % 2 == 1), $urandom, ($urandom % 8) == 0);
      cyc();
    end

    // Reset with two outstanding: a late response is not routed.
    do_reset(1'b0);
    drive(2'b11, 32'h1, 32'h2, 1'b1, 1'b0, '0, 1'b0); cyc();
    drive(2'b11, 32'h1, 32'h2, 1'b1, 1'b0, '0, 1'b0); cyc();
    chk("pre_rst_busy", busy_o, 1'b1);
    do_reset(1'b1);
    drive('0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_instr_port_arbiter.md
Name: riscv_instr_port_arbiter

Overview:
Shares one instruction-memory/I$ request port (req/gnt/addr, rvalid/rdata, PMP error) between NB_REQ fetch requesters, e.g. the core prefetch buffer and a debug/secondary fetch unit. Requests pass combinationally; responses are returned in order. A small ID FIFO records who owns each outstanding response and routes rvalid back to that requester. Sits between the requesters' instr_* ports and the memory side.

Parameters:
NB_REQ, 2, number of requesters (2..8)
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (1..4)
ADDR_W, 32, address width
DATA_W, 32, rdata width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req_i  in  NB_REQ  per-requester request
addr_i  in  NB_REQ x ADDR_W  per-requester address
gnt_o  out  NB_REQ  per-requester grant
rvalid_o  out  NB_REQ  per-requester response valid
rdata_o  out  DATA_W  response data, broadcast to all requesters
err_pmp_o  out  NB_REQ  PMP fault, qualified with the same requester's grant
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  ADDR_W  memory address
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_W  memory response data
mem_err_pmp_i  in  1  PMP fault, valid with mem_gnt_i
busy_o  out  1  outstanding count != 0 or mem_req_o
proto_err_o  out  1  sticky: rvalid received with ID FIFO empty

Behaviour:
- Reset: rr_ptr_q=0, lock_q=0, ID FIFO empty, proto_err_o=0. Combinational outputs are 0 while all req_i are low.
- Winner selection:
  - If lock_q and req_i[lock_id_q] are high, the winner is lock_id_q.
  - Otherwise, round-robin: the first set req_i at index rr_ptr_q, rr_ptr_q+1, ... mod NB_REQ.
- can_issue = (count < MAX_OUTSTANDING) | mem_rvalid_i. A same-cycle pop frees a slot; this combinational rvalid->req path is intended.
- mem_req_o = (|req_i) & can_issue. mem_addr_o = addr_i[winner]. Address is zero when no request is present.
- gnt_o[winner] = mem_req_o & mem_gnt_i. Every other gnt_o bit is 0.
- Handshake (mem_req_o & mem_gnt_i):
  - rr_ptr_q <= (winner+1) mod NB_REQ; lock_q <= 0.
  - If !mem_err_pmp_i, push the winner ID.
  - If mem_err_pmp_i, set err_pmp_o[winner]=1 and push nothing, since no rvalid follows a PMP fault.
- Request not granted (mem_req_o & !mem_gnt_i): lock_q <= 1, lock_id_q <= winner.
  - The locked requester may change its address while waiting (branch retarget); the arbiter forwards the new address.
  - If the locked requester drops req_i, the lock releases that same cycle and arbitration proceeds normally.
- Request blocked by a full FIFO (|req_i & !can_issue): the candidate is still computed and lock_q is set to it, so ownership does not migrate while blocked.
- Response (mem_rvalid_i):
  - FIFO not empty: pop the head and assert rvalid_o[head]=1 in the same cycle; rdata_o = mem_rdata_i (zero latency).
  - FIFO empty: all rvalid_o stay 0 and proto_err_o is set (sticky until reset).
- Push and pop in the same cycle: count is unchanged; the push writes behind the popped head.
- Full with no pop: mem_req_o=0 and all gnt_o=0.
- ID width = clog2(NB_REQ), minimum 1. Count width = clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset asserted mid-transaction: all state clears asynchronously. Responses still in flight after reset are dropped; that case is covered by proto_err_o.

Optional Feature:
RISCV_INSTR_ARB_PERF_EN
- Defined: adds per-requester 32-bit counters grant_cnt_o[NB_REQ] and stall_cnt_o[NB_REQ].
  - stall_cnt_o counts cycles where req_i[i] & !gnt_o[i].
  - Counters saturate at all-ones, reset to 0, and clear synchronously on input perf_clr_i.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package riscv_instr_arb_pkg: ID_W and count-width functions, the arbiter state struct (rr_ptr, lock, lock_id), and the perf counter width constant.
- Sub-module riscv_instr_arb_id_fifo: parameterised-depth ID FIFO with push/pop/count, same-cycle push+pop support, and fall-through head read.

Test Plan:
- Simultaneous requests: req_i=2'b11, mem_gnt_i=1 every cycle -> grants alternate 01,10,01,...; mem_addr_o follows the winner.
- Lock on stall: requester 0 gets mem_gnt_i=0 for 3 cycles while req_i[1]=1, and changes addr 0x100->0x200 -> mem_addr_o=0x200; gnt_o[0] on the 4th cycle; req 1 granted next.
- Full FIFO: MAX_OUTSTANDING=2 with two grants and no rvalid -> mem_req_o=0. rvalid arrives in cycle 3 -> rvalid_o routed to the first owner and mem_req_o=1 in that same cycle.
- Interleaved owners: grant req0 @0x10, then req1 @0x20; rvalid with data A then B -> rvalid_o=01 with rdata A, then 10 with rdata B.
- PMP fault: mem_gnt_i=1 & mem_err_pmp_i=1 for req1 -> err_pmp_o=10, count unchanged, busy_o drops once req_i=0.
- Protocol error and reset: mem_rvalid_i with an empty FIFO -> proto_err_o=1 and stays 1. Reset asserted with 2 outstanding -> count=0, proto_err_o=0, no rvalid_o.
